// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: one full_subtractor cell reused across WIDTH bit
// positions, LSB first, computing a - b - bin behind a start/done handshake.
`timescale 1ns/1ps

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic in,
    output logic Diff,
    output logic Borr
);
    assign Diff = a ^ b ^ in;
    assign Borr = (~a & b) | (~(a ^ b) & in);
endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_sh, b_sh, diff_sh;
    logic              borrow;
    logic [CW-1:0]     count;
    logic              fs_diff, fs_borr;
    logic              last;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .in   (borrow),
        .Diff (fs_diff),
        .Borr (fs_borr)
    );

    assign last = (count == CW'(WIDTH - 1));
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // diff/bout are only written on the final shift, so they hold between ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            count   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    borrow <= bin;
                    count  <= '0;
                end
                SHIFT: begin
                    diff_sh <= {fs_diff, diff_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    borrow  <= fs_borr;
                    count   <= count + 1'b1;
                    if (last) begin
                        diff <= {fs_diff, diff_sh[WIDTH-1:1]};
                        bout <= fs_borr;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
